// File: rtl/alu_ctrl_fsm.sv
// alu_ctrl_fsm: multi-cycle RV32 subset control unit sequencing IF/ID/EX/MEM/WB.
module alu_ctrl_fsm #(
  parameter logic [4:0] OP_ADD  = 5'b00011,
  parameter logic [4:0] OP_SUB  = 5'b00100,
  parameter logic [4:0] OP_SLTI = 5'b01000,
  parameter logic [4:0] OP_JAL  = 5'b10000,
  parameter logic [4:0] OP_JALR = 5'b00000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] instr,
  input  logic        imem_rdy,
  input  logic        dmem_rdy,
  input  logic        zero,
  output logic        imem_req,
  output logic        ir_we,
  output logic [4:0]  alu_op,
  output logic        alu_src_a,
  output logic        alu_src_b,
  output logic        pc_we,
  output logic [1:0]  pc_src,
  output logic        reg_we,
  output logic [1:0]  wb_sel,
  output logic        mem_re,
  output logic        mem_we,
  output logic        illegal,
  output logic [2:0]  state
);
  localparam logic [2:0] S_IF = 3'd0, S_ID = 3'd1, S_EX = 3'd2, S_MEM = 3'd3, S_WB = 3'd4, S_HALT = 3'd7;
  localparam logic [2:0] C_R = 3'd0, C_I = 3'd1, C_LW = 3'd2, C_SW = 3'd3, C_BEQ = 3'd4, C_JAL = 3'd5, C_JALR = 3'd6;

  logic [2:0]  r_st, w_nst;
  logic [16:0] r_ir;
  logic [2:0]  r_cls, w_cls;
  logic [4:0]  r_op, w_op;
  logic        r_ill, w_ill;
  logic        w_jmp;
  logic [6:0]  w_opc, w_f7;
  logic [2:0]  w_f3;
  logic        w_unused;

  // only opcode/funct fields matter for control; register and immediate bits belong to the datapath
  assign w_unused = ^{instr[24:15], instr[11:7]};
  assign {w_f7, w_f3, w_opc} = r_ir;
  assign w_jmp = (r_cls == C_JAL) || (r_cls == C_JALR);
  assign illegal = r_ill;
  assign state = r_st;

  always_comb begin
    w_cls = C_R;
    w_op  = OP_ADD;
    w_ill = 1'b0;
    if (w_opc == 7'b0110011 && w_f3 == 3'b000 && w_f7 == 7'b0000000) begin
      w_cls = C_R; w_op = OP_ADD;
    end else if (w_opc == 7'b0110011 && w_f3 == 3'b000 && w_f7 == 7'b0100000) begin
      w_cls = C_R; w_op = OP_SUB;
    end else if (w_opc == 7'b0010011 && w_f3 == 3'b000) begin
      w_cls = C_I; w_op = OP_ADD;
    end else if (w_opc == 7'b0010011 && w_f3 == 3'b010) begin
      w_cls = C_I; w_op = OP_SLTI;
    end else if (w_opc == 7'b0000011 && w_f3 == 3'b010) begin
      w_cls = C_LW; w_op = OP_ADD;
    end else if (w_opc == 7'b0100011 && w_f3 == 3'b010) begin
      w_cls = C_SW; w_op = OP_ADD;
    end else if (w_opc == 7'b1100011 && w_f3 == 3'b000) begin
      w_cls = C_BEQ; w_op = OP_SUB;
    end else if (w_opc == 7'b1101111) begin
      w_cls = C_JAL; w_op = OP_JAL;
    end else if (w_opc == 7'b1100111 && w_f3 == 3'b000) begin
      w_cls = C_JALR; w_op = OP_JALR;
    end else begin
      w_ill = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst)
    if (rst) r_st <= S_IF;
    else r_st <= w_nst;

  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      r_ir  <= '0;
      r_cls <= C_R;
      r_op  <= '0;
      r_ill <= 1'b0;
    end else begin
      if (r_st == S_IF && imem_rdy) r_ir <= {instr[31:25], instr[14:12], instr[6:0]};
      if (r_st == S_ID) begin
        r_cls <= w_cls;
        r_op  <= w_op;
        r_ill <= r_ill | w_ill;
      end
    end

  always_comb begin
    w_nst = S_IF;
    case (r_st)
      S_IF:   w_nst = imem_rdy ? S_ID : S_IF;
      S_ID:   w_nst = w_ill ? S_HALT : S_EX;
      S_EX:   w_nst = (r_cls == C_R || r_cls == C_I) ? S_WB : (r_cls == C_LW || r_cls == C_SW) ? S_MEM : S_IF;
      S_MEM:  w_nst = !dmem_rdy ? S_MEM : (r_cls == C_LW) ? S_WB : S_IF;
      S_WB:   w_nst = S_IF;
      S_HALT: w_nst = S_HALT;
      default: w_nst = S_IF;
    endcase
  end

  // every output is forced idle while rst is high, since the state register clears asynchronously
  always_comb begin
    imem_req  = 1'b0;
    ir_we     = 1'b0;
    alu_op    = OP_ADD;
    alu_src_a = 1'b0;
    alu_src_b = 1'b0;
    pc_we     = 1'b0;
    pc_src    = 2'd0;
    reg_we    = 1'b0;
    wb_sel    = 2'd0;
    mem_re    = 1'b0;
    mem_we    = 1'b0;
    if (!rst)
      case (r_st)
        S_IF: begin
          imem_req = 1'b1;
          ir_we    = imem_rdy;
        end
        S_EX: begin
          alu_op    = r_op;
          alu_src_a = r_cls == C_JAL;
          alu_src_b = r_cls != C_R && r_cls != C_BEQ;
          reg_we    = w_jmp;
          wb_sel    = w_jmp ? 2'd2 : 2'd0;
          pc_we     = w_jmp || r_cls == C_BEQ;
          pc_src    = w_jmp ? 2'd2 : {1'b0, r_cls == C_BEQ && zero};
        end
        S_MEM: begin
          alu_op    = r_op;
          alu_src_b = 1'b1;
          mem_re    = r_cls == C_LW;
          mem_we    = r_cls == C_SW;
          pc_we     = r_cls == C_SW && dmem_rdy;
        end
        S_WB: begin
          reg_we = 1'b1;
          wb_sel = {1'b0, r_cls == C_LW};
          pc_we  = 1'b1;
        end
        default: ;
      endcase
  end
endmodule
